// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// legal byte-enable patterns and the byte-enable alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Byte-enable patterns a naturally aligned byte, halfword or word access can use
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // True when be is a legal pattern whose lowest lane matches the byte offset
    function automatic logic be_aligned(input logic [1:0] addr_lo, input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        case (addr_lo)
            2'd0: ok = (be == BE_BYTE0) || (be == BE_HALF0) || (be == BE_WORD);
            2'd1: ok = (be == BE_BYTE1);
            2'd2: ok = (be == BE_BYTE2) || (be == BE_HALF1);
            2'd3: ok = (be == BE_BYTE3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: single port, synchronous byte-lane write,
// combinational read of the addressed word. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Write only the byte lanes whose enable is set; other lanes keep their value
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// performs the access on dmem_array and returns data/fault on a response channel.
// Optional feature macro: DMEM_RESPONDER_ALIGN_CHK_EN (misaligned accesses fault).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Array size in bytes, one bit wider than the address so 2**30 words still fits
    localparam logic [32:0] LIMIT     = 33'd4 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic                    wr_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;

    logic [31:0]             offset;
    logic                    range_fault;
    logic                    align_fault;
    logic                    fault;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    mem_we;
    logic [31:0]             mem_rdata;

    // Addresses below the base or past the end fault; there is no wrap-around aliasing
    assign offset      = addr_q - BASE_ADDR;
    assign range_fault = (addr_q < BASE_ADDR) || ({1'b0, offset} >= LIMIT);
    assign word_idx    = offset[ADDR_WIDTH+1:2];

`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
    assign align_fault = (addr_q[1:0] != 2'b00) || !be_aligned(addr_q[1:0], be_q);
`else
    assign align_fault = 1'b0;
`endif

    assign fault  = range_fault || align_fault;
    assign mem_we = (state == ACCESS) && wr_q && !fault;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_q),
        .addr  (word_idx),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // Request/wait/access/response sequencer with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_wr;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    rsp_err   <= fault;
                    rsp_rdata <= (wr_q || fault) ? 32'h0 : mem_rdata;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0),
// randomized traffic checked against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [16];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // Reference: memory as a plain word array, faults from the address rules
    function automatic void ref_apply(input bit which, input logic wr, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      output logic [31:0] rdata, output logic err);
        logic [63:0] base, span, off;
        int idx;
        base  = which ? 64'h1000 : 64'h0;
        span  = which ? 64'd64 : 64'd1024;
        off   = {32'h0, addr} - base;
        err   = ({32'h0, addr} < base) || (off >= span);
`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
        if (addr[1:0] != 2'b00 || !(be inside {4'b0001, 4'b0011, 4'b1111})) err = 1'b1;
`endif
        rdata = 32'h0;
        if (!err) begin
            idx = int'(off >> 2);
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        if (which) mem_b[idx][8*i +: 8] = wdata[8*i +: 8];
                        else       mem_a[idx][8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata = which ? mem_b[idx] : mem_a[idx];
            end
        end
    endfunction

    // Drive one transaction; lat counts edges from acceptance to rsp_valid being sampled high
    task automatic do_txn(input bit which, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat, output bit tmo);
        int n;
        tmo = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0;
        @(negedge clk);
        req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        if (which) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        n = 0;
        while (((which ? b_req_ready : a_req_ready) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tmo = 1'b1; a_req_valid = 1'b0; b_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (((which ? b_rsp_valid : a_rsp_valid) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tmo = 1'b1;
            return;
        end
        lat   = n + 1;
        rdata = which ? b_rsp_rdata : a_rsp_rdata;
        err   = which ? b_rsp_err : a_rsp_err;
        if (which) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_a_hs: ready=%b valid=%b, required 1/0", a_req_ready, a_rsp_valid);
        end
        checks++; if (a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_a_data: rdata=%h err=%b, required 0/0", a_rsp_rdata, a_rsp_err);
        end
        checks++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_b: ready=%b valid=%b rdata=%h err=%b", b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release: ready=%b valid=%b, required 1/0", a_req_ready, a_rsp_valid);
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, er, d; logic e, ee; int lat; bit tmo;
        for (int w = 0; w < 256 + 16; w++) begin
            bit which;
            logic [31:0] addr;
            which = (w >= 256);
            addr  = which ? 32'h1000 + 32'((w - 256) * 4) : 32'(w * 4);
            d = $urandom();
            do_txn(which, 1'b1, addr, d, 4'hF, rd, e, lat, tmo);
            ref_apply(which, 1'b1, addr, d, 4'hF, er, ee);
            checks++; if (tmo || e !== 1'b0) begin
                errors++; $display("[TB] FAIL fill: addr=%h err=%b tmo=%b, required err=0", addr, e, tmo);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, er; logic e, ee; int lat; bit tmo;
        do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, tmo);
        ref_apply(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er, ee);
        checks++; if (tmo || lat !== 4) begin
            errors++; $display("[TB] FAIL store_latency: lat=%0d tmo=%b, required 4", lat, tmo);
        end
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL store_rsp: rdata=%h err=%b, required 0/0", rd, e);
        end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, tmo);
        checks++; if (tmo || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("[TB] FAIL load_back: rdata=%h err=%b, required deadbeef/0", rd, e);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd, er; logic e, ee; int lat; bit tmo;
        do_txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat, tmo);
        ref_apply(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, er, ee);
`ifndef DMEM_RESPONDER_ALIGN_CHK_EN
        do_txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat, tmo);
        ref_apply(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, er, ee);
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || rd !== 32'h11BB33DD || e !== 1'b0) begin
            errors++; $display("[TB] FAIL byte_mask: rdata=%h err=%b, required 11bb33dd/0", rd, e);
        end
`endif
        do_txn(1'b0, 1'b1, 32'h20, 32'h55667788, 4'b0000, rd, e, lat, tmo);
        ref_apply(1'b0, 1'b1, 32'h20, 32'h55667788, 4'b0000, er, ee);
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat, tmo);
        ref_apply(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, er, ee);
        checks++; if (tmo || rd !== er || e !== ee) begin
            errors++; $display("[TB] FAIL be_zero: rdata=%h err=%b, required %h/%b", rd, e, er, ee);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        int n;
        exp_d = mem_a[17];
        @(negedge clk);
        req_wr = 1'b0; req_addr = 32'h44; req_wdata = 32'h0; req_be = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (a_rsp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_valid_timeout: valid=%b, required 1", a_rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== exp_d || a_rsp_err !== 1'b0 || a_req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b, required 1/%h/0/0",
                                   c, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready, exp_d);
            end
            @(negedge clk);
        end
        a_rsp_ready = 1'b1;
        checks++; if (a_req_ready !== 1'b0 || a_rsp_rdata !== exp_d) begin
            errors++; $display("[TB] FAIL bp_handshake_cycle: ready=%b rdata=%h, required 0/%h", a_req_ready, a_rsp_rdata, exp_d);
        end
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_after: ready=%b valid=%b, required 1/0", a_req_ready, a_rsp_valid);
        end
    endtask

    task automatic test_range_fault();
        logic [31:0] rd, er, v; logic e, ee; int lat; bit tmo;
        do_txn(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, v, e, lat, tmo);
        checks++; if (tmo || v !== mem_a[0]) begin
            errors++; $display("[TB] FAIL range_pre_load: rdata=%h, required %h", v, mem_a[0]);
        end
        do_txn(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL range_store_400: err=%b rdata=%h, required 1/0", e, rd);
        end
        do_txn(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || rd !== v || e !== 1'b0) begin
            errors++; $display("[TB] FAIL range_reread: rdata=%h err=%b, required %h/0", rd, e, v);
        end
        do_txn(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL range_high: err=%b rdata=%h, required 1/0", e, rd);
        end
        do_txn(1'b1, 1'b0, 32'h0FFC, 32'h0, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL range_below_base: err=%b rdata=%h, required 1/0", e, rd);
        end
        do_txn(1'b1, 1'b1, 32'h1040, 32'hFFFF_FFFF, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || e !== 1'b1) begin
            errors++; $display("[TB] FAIL range_past_end: err=%b, required 1", e);
        end
        do_txn(1'b1, 1'b0, 32'h103C, 32'h0, 4'hF, rd, e, lat, tmo);
        ref_apply(1'b1, 1'b0, 32'h103C, 32'h0, 4'hF, er, ee);
        checks++; if (tmo || rd !== er || e !== 1'b0) begin
            errors++; $display("[TB] FAIL range_last_word: rdata=%h err=%b, required %h/0", rd, e, er);
        end
    endtask

    task automatic test_wait0();
        logic [31:0] rd, er; logic e, ee; int lat; bit tmo;
        do_txn(1'b1, 1'b0, 32'h1010, 32'h0, 4'hF, rd, e, lat, tmo);
        ref_apply(1'b1, 1'b0, 32'h1010, 32'h0, 4'hF, er, ee);
        checks++; if (tmo || lat !== 2) begin
            errors++; $display("[TB] FAIL wait0_latency: lat=%0d, required 2", lat);
        end
        checks++; if (rd !== er || e !== ee) begin
            errors++; $display("[TB] FAIL wait0_data: rdata=%h err=%b, required %h/%b", rd, e, er, ee);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, er, addr, d; logic e, ee, wr; logic [3:0] be; int lat; bit tmo, which;
        for (int t = 0; t < 80; t++) begin
            which = (t % 2 == 1);
            wr    = 1'($urandom_range(0, 1));
            d     = $urandom();
            be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0)
                addr = which ? 32'h1000 + 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 1023));
            else
                addr = which ? 32'($urandom_range(32'h0F00, 32'h10FF)) : $urandom();
`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
            if ($urandom_range(0, 1) == 0) begin addr[1:0] = 2'b00; be = 4'hF; end
`endif
            do_txn(which, wr, addr, d, be, rd, e, lat, tmo);
            ref_apply(which, wr, addr, d, be, er, ee);
            checks++; if (tmo || rd !== er || e !== ee || lat !== (which ? 2 : 4)) begin
                errors++; $display("[TB] FAIL random%0d: dut%0d wr=%b addr=%h be=%b got rdata=%h err=%b lat=%0d, required %h/%b/%0d",
                                   t, which, wr, addr, be, rd, e, lat, er, ee, which ? 2 : 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, old; logic e; int lat; bit tmo;
        old = mem_a[12];
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h30; req_wdata = ~old; req_be = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 1/0/0/0",
                               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat, tmo);
        checks++; if (tmo || rd !== old || e !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_untouched: rdata=%h err=%b, required %h/0", rd, e, old);
        end
    endtask

    task automatic test_alignment();
        logic [31:0] rd; logic e; int lat; bit tmo;
        do_txn(1'b0, 1'b0, 32'h31, 32'h0, 4'hF, rd, e, lat, tmo);
`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
        checks++; if (tmo || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("[TB] FAIL align_fault: err=%b rdata=%h, required 1/0", e, rd);
        end
`else
        checks++; if (tmo || e !== 1'b0 || rd !== mem_a[12]) begin
            errors++; $display("[TB] FAIL align_ignored: err=%b rdata=%h, required 0/%h", e, rd, mem_a[12]);
        end
`endif
    endtask

    initial begin
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        test_reset();
        test_fill();
        test_store_load();
        test_byte_mask();
        test_backpressure();
        test_range_fault();
        test_wait0();
        test_random();
        test_reset_mid();
        test_alignment();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
